mux32_arbiter: RTL

Round-robin arbiter sharing one 32-input word multiplexer among 32 requesters. Drives the mux's 5-bit select and a one-hot grant, and paces transfers to a single downstream consumer with a valid/ready handshake. Grants are held for a bounded burst, then rotated fairly. The block contains control only; the data path stays in the 32-way mux, whose `s` input is driven by `sel`.

---
 rtl/mux32_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mux32_arbiter.sv
// ============================================================================
// Module   : mux32_arbiter
// Purpose  : Round-robin arbiter that owns the select of a shared 32-way word
//            multiplexer. It grants one requester at a time and holds the
//            grant for at most MAX_BEATS accepted beats. It then rotates
//            priority to the requester after the current owner. Transfers to
//            the single downstream consumer are paced with valid/ready.
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-high reset
//            req[31:0]  per-requester request (held while data is on mux input)
//            mask[31:0] per-requester enable, qualifies req
//            out_ready  downstream accepts the current beat
//            out_valid  mux output valid for the granted requester
//            sel[4:0]   registered mux select (index of granted requester)
//            grant[31:0] registered one-hot grant, zero when idle
//            ack[31:0]  one-hot, high for the requester whose beat is accepted
//            busy       a grant is currently held
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux32_arbiter #(
    parameter int MAX_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req,
    input  logic [31:0] mask,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [4:0]  sel,
    output logic [31:0] grant,
    output logic [31:0] ack,
    output logic        busy
);

    // Beat counter only needs to reach MAX_BEATS-1.
    localparam int               CNT_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAX_BEATS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [4:0]       ptr;
    logic [4:0]       ptr_nxt;
    logic [4:0]       sel_nxt;
    logic [31:0]      grant_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [31:0]      ereq;
    logic [4:0]       start;
    logic [4:0]       win_idx;
    logic             win_found;
    logic             accept;
    logic             rel;

    assign ereq = req & mask;

    // While busy the only time the winner matters is on release, when the
    // search starts just past the current owner; in idle it starts at ptr.
    assign start = (state == S_BUSY) ? (sel + 5'd1) : ptr;

    // Rotating priority search: scanning offsets from high to low makes the
    // smallest offset (closest to start, going upward mod 32) win.
    always_comb begin
        win_idx = start;
        for (int i = 31; i >= 0; i--) begin
            if (ereq[start + 5'(i)]) begin
                win_idx = start + 5'(i);
            end
        end
    end

    assign win_found = |ereq;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ptr   <= 5'd0;
            sel   <= 5'd0;
            grant <= 32'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            grant <= grant_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        grant_nxt = grant;
        cnt_nxt   = cnt;
        rel       = 1'b0;

        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt = S_BUSY;
                    sel_nxt   = win_idx;
                    grant_nxt = 32'd1 << win_idx;
                    cnt_nxt   = '0;
                end
            end

            S_BUSY: begin
                // Owner dropped/masked, or its last allowed beat is accepted.
                rel = ~ereq[sel] | (accept & (cnt == C_LAST));
                if (rel) begin
                    ptr_nxt = sel + 5'd1;
                    cnt_nxt = '0;
                    if (win_found) begin
                        sel_nxt   = win_idx;
                        grant_nxt = 32'd1 << win_idx;
                    end else begin
                        state_nxt = S_IDLE;
                        grant_nxt = 32'd0;
                    end
                end else if (accept) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                grant_nxt = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: combinational from inputs and registered grant only;
    // out_ready never reaches sel.
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state == S_BUSY);
        out_valid = busy & ereq[sel];
        accept    = out_valid & out_ready;
        ack       = accept ? grant : 32'd0;
    end

endmodule

`default_nettype wire
